// File: rtl/dpram_burst_master_if.sv
// Command, write-data and read-response streams of one dpram_burst_master.
// The requester side uses the master modport and the controller uses the slave modport.
interface dpram_burst_master_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;

  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_last;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wdata_valid, wdata,
    input  wdata_ready,
    input  rdata_valid, rdata, rdata_last,
    output rdata_ready
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wdata_valid, wdata,
    output wdata_ready,
    output rdata_valid, rdata, rdata_last,
    input  rdata_ready
  );
endinterface

// File: rtl/dpram_burst_master.sv
// Burst read/write sequencer for one port of a synchronous-read dual-port RAM,
// with a two-entry response FIFO that absorbs the one-cycle RAM read latency.
module dpram_burst_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  dpram_burst_master_if.slave bus,
  output logic                busy,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_data,
  output logic                ram_we,
  input  logic [DATA_W-1:0]   ram_q
);

  localparam int CNT_W = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [CNT_W-1:0]       beats_q, beats_d;
  logic                   ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]      ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]      ram_data_q, ram_data_d;
  logic                   inflight_q, inflight_d;
  logic                   inflight_last_q, inflight_last_d;
  logic [1:0][DATA_W-1:0] fifo_data_q, fifo_data_d;
  logic [1:0]             fifo_last_q, fifo_last_d;
  logic [1:0]             count_q, count_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;

  logic       pop;
  logic [1:0] occupancy;
  logic       last_beat;
  logic       rd_issue;

  // A beat leaving the FIFO this cycle frees its slot for a new issue in the same cycle,
  // which is what sustains one beat per cycle with rdata_ready held high.
  assign pop       = (count_q != 2'd0) && bus.rdata_ready;
  assign occupancy = count_q + 2'(inflight_q) - 2'(pop);
  assign last_beat = (beats_q == CNT_W'(1));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    beats_d         = beats_q;
    ram_we_d        = 1'b0;
    ram_addr_d      = ram_addr_q;
    ram_data_d      = ram_data_q;
    rd_issue        = 1'b0;
    bus.cmd_ready   = 1'b0;
    bus.wdata_ready = 1'b0;

    case (state_q)
      IDLE: begin
        bus.cmd_ready = rst_n;
        if (bus.cmd_valid && bus.cmd_ready) begin
          addr_d  = bus.cmd_addr;
          beats_d = CNT_W'(bus.cmd_len) + CNT_W'(1);
          state_d = bus.cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        bus.wdata_ready = 1'b1;
        if (bus.wdata_valid) begin
          ram_we_d   = 1'b1;
          ram_addr_d = addr_q;
          ram_data_d = bus.wdata;
          addr_d     = addr_q + ADDR_W'(1);
          beats_d    = beats_q - CNT_W'(1);
          if (last_beat) state_d = IDLE;
        end
      end
      READ: begin
        if (occupancy < 2'd2) begin
          rd_issue   = 1'b1;
          ram_addr_d = addr_q;
          addr_d     = addr_q + ADDR_W'(1);
          beats_d    = beats_q - CNT_W'(1);
          if (last_beat) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((count_q == 2'd0) && !inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    inflight_d      = rd_issue;
    inflight_last_d = rd_issue && last_beat;
  end

  // Response FIFO: capture the RAM output one cycle after each issue, pop on handshake.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (inflight_q) begin
      fifo_data_d[wr_ptr_q] = ram_q;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + 2'(inflight_q) - 2'(pop);
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      beats_q         <= '0;
      ram_we_q        <= 1'b0;
      ram_addr_q      <= '0;
      ram_data_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      // NOTE: the two FIFO entries are reset as well; it is only two words and it
      // guarantees no beat from an aborted burst can ever resurface.
      fifo_data_q     <= '0;
      fifo_last_q     <= '0;
      count_q         <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      beats_q         <= beats_d;
      ram_we_q        <= ram_we_d;
      ram_addr_q      <= ram_addr_d;
      ram_data_q      <= ram_data_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
    end
  end

  // Read addresses go straight to the RAM in the issue cycle; the registered copy
  // keeps the address steady afterwards and carries the write-beat address.
  assign ram_addr        = rd_issue ? addr_q : ram_addr_q;
  assign ram_data        = ram_data_q;
  assign ram_we          = ram_we_q;
  assign busy            = (state_q != IDLE);
  assign bus.rdata_valid = (count_q != 2'd0);
  assign bus.rdata       = bus.rdata_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.rdata_last  = bus.rdata_valid & fifo_last_q[rd_ptr_q];

endmodule
